uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter granting one of NUM_SRC message sources
// exclusive use of a single UART transmitter, with a post-release idle gap.
//   clk, rst_n          clock, asynchronous active-low reset
//   i_want[NUM_SRC]     per-source message pending (level)
//   i_req/i_data/i_done per-source byte valid, byte, end-of-message pulse
//   o_idle[NUM_SRC]     one-hot grant to the owning source
//   o_cts[NUM_SRC]      per-source byte accepted
//   o_tx_data/o_tx_req  byte and byte-valid towards the transmitter
//   i_tx_cts/i_tx_idle  transmitter accept and line-idle
//   o_grant_id          current grant in GRANT, last granted source otherwise
//   o_busy              arbiter not idle
//   o_pkt_count         completed grants (done or timeout), wraps
module uart_tx_arb #(
    parameter int NUM_SRC    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   i_want,
    input  logic [NUM_SRC-1:0]   i_req,
    input  logic [8*NUM_SRC-1:0] i_data,
    input  logic [NUM_SRC-1:0]   i_done,
    output logic [NUM_SRC-1:0]   o_idle,
    output logic [NUM_SRC-1:0]   o_cts,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_req,
    input  logic                 i_tx_cts,
    input  logic                 i_tx_idle,
    output logic [2:0]           o_grant_id,
    output logic                 o_busy,
    output logic [15:0]          o_pkt_count
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_q, last_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  to_q, to_d;
    logic [15:0] pkt_q, pkt_d;

    logic               req_g, done_g, found, rel;
    logic [7:0]         data_g;
    logic [2:0]         win;
    logic [NUM_SRC-1:0] gnt_oh;

    // Per-source selection of the granted source's signals and the
    // round-robin winner: first look above last, then wrap from 0.
    always_comb begin
        req_g  = 1'b0;
        done_g = 1'b0;
        data_g = 8'd0;
        gnt_oh = '0;
        win    = last_q;
        found  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_q == 3'(k)) begin
                req_g  = i_req[k];
                done_g = i_done[k];
                data_g = i_data[8*k +: 8];
            end
            gnt_oh[k] = (state_q == GRANT) && (grant_q == 3'(k));
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && i_want[k] && 3'(k) > last_q) begin
                win   = 3'(k);
                found = 1'b1;
            end
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && i_want[k]) begin
                win   = 3'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        to_d    = to_q;
        pkt_d   = pkt_q;
        rel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_tx_idle && |i_want) begin
                    state_d = GRANT;
                    grant_d = win;
                    to_d    = 8'd0;
                end
            end
            GRANT: begin
                // done and timeout in the same cycle collapse into one release
                rel  = done_g || (!req_g && to_q == 8'(TIMEOUT - 1));
                to_d = req_g ? 8'd0 : to_q + 8'd1;
                if (rel) begin
                    state_d = GAP;
                    last_d  = grant_q;
                    pkt_d   = pkt_q + 16'd1;
                    gap_d   = 8'(GAP_CYCLES - 1);
                    to_d    = 8'd0;
                end
            end
            GAP: begin
                if (gap_q == 8'd0) state_d = IDLE;
                else gap_d = gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 3'd0;
            last_q  <= 3'(NUM_SRC - 1);
            gap_q   <= 8'd0;
            to_q    <= 8'd0;
            pkt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            pkt_q   <= pkt_d;
        end
    end

    assign o_idle      = gnt_oh;
    assign o_cts       = (i_tx_cts && req_g) ? gnt_oh : '0;
    assign o_tx_req    = (state_q == GRANT) && req_g;
    assign o_tx_data   = (state_q == GRANT) ? data_g : 8'd0;
    // last_q resets to NUM_SRC-1, so the id is forced low while in reset
    assign o_grant_id  = !rst_n ? 3'd0 : (state_q == GRANT) ? grant_q : last_q;
    assign o_busy      = state_q != IDLE;
    assign o_pkt_count = pkt_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized self-checking bench for uart_tx_arb (4 sources).
module tb_uart_tx_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_want, i_req, i_done;
    logic [31:0] i_data;
    logic        i_tx_cts, i_tx_idle;
    logic [3:0]  o_idle, o_cts;
    logic [7:0]  o_tx_data;
    logic        o_tx_req, o_busy;
    logic [2:0]  o_grant_id;
    logic [15:0] o_pkt_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_last = 3;
    int exp_pkt = 0;

    uart_tx_arb #(.NUM_SRC(4), .GAP_CYCLES(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .i_want(i_want), .i_req(i_req), .i_data(i_data),
        .i_done(i_done), .o_idle(o_idle), .o_cts(o_cts), .o_tx_data(o_tx_data),
        .o_tx_req(o_tx_req), .i_tx_cts(i_tx_cts), .i_tx_idle(i_tx_idle),
        .o_grant_id(o_grant_id), .o_busy(o_busy), .o_pkt_count(o_pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Round robin as written in the requirements: search last+1 .. last+N.
    function automatic int rr_pick(input int last, input logic [3:0] w);
        for (int i = 1; i <= 4; i++)
            if (w[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_want = 0; i_req = 0; i_done = 0; i_data = 0; i_tx_cts = 0; i_tx_idle = 1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 3;
        exp_pkt = 0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && o_busy; n++) @(negedge clk);
        #1;
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_idle: busy=%b required 0", o_busy);
        end
    endtask

    // Grant the round-robin winner of want, pass nbytes random bytes with
    // noise on other sources, release by done, then measure the gap.
    task automatic run_grant(input logic [3:0] want, input int nbytes);
        int exp;
        int g;
        logic [3:0] oh;
        logic gap_bad;
        exp = rr_pick(exp_last, want);
        oh = 4'b0001 << exp;
        i_want = want; i_tx_idle = 1; i_req = 0; i_done = 0;
        @(negedge clk); #1;
        vectors++;
        if (o_idle !== oh || o_grant_id !== 3'(exp) || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL grant: idle=%b id=%0d busy=%b required idle=%b id=%0d busy=1", o_idle, o_grant_id, o_busy, oh, exp);
        end
        for (int b = 0; b < nbytes; b++) begin
            i_req = 4'($urandom) | oh;
            i_data = $urandom;
            i_tx_cts = 1'($urandom);
            i_done = 4'($urandom) & ~oh;
            #1;
            vectors++;
            if (o_tx_req !== 1'b1 || o_tx_data !== i_data[8*exp +: 8] ||
                o_cts !== (i_tx_cts ? oh : 4'b0) || o_idle !== oh) begin
                miscompares++;
                $display("FAIL byte: req=%b data=%h cts=%b idle=%b required req=1 data=%h cts=%b idle=%b",
                         o_tx_req, o_tx_data, o_cts, o_idle, i_data[8*exp +: 8], i_tx_cts ? oh : 4'b0, oh);
            end
            @(negedge clk);
        end
        i_req = 0; i_data = $urandom; i_done = oh;
        #1;
        vectors++;
        if (o_idle !== oh || o_tx_req !== 1'b0 || o_tx_data !== i_data[8*exp +: 8]) begin
            miscompares++;
            $display("FAIL done_cycle: idle=%b req=%b data=%h required idle=%b req=0 data=%h",
                     o_idle, o_tx_req, o_tx_data, oh, i_data[8*exp +: 8]);
        end
        @(negedge clk);
        i_done = 0;
        exp_last = exp;
        exp_pkt++;
        gap_bad = 1'b0;
        for (g = 0; g < 100; g++) begin
            #1;
            if (!o_busy) break;
            if (o_tx_req !== 1'b0 || o_idle !== 4'b0 || o_cts !== 4'b0 || o_grant_id !== 3'(exp)) gap_bad = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (g !== 16 || gap_bad) begin
            miscompares++;
            $display("FAIL gap: length=%0d outputs_bad=%b required length=16 outputs_bad=0", g, gap_bad);
        end
        vectors++;
        if (o_pkt_count !== 16'(exp_pkt)) begin
            miscompares++;
            $display("FAIL pkt_count: got %0d required %0d", o_pkt_count, exp_pkt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_want = 4'hF; i_req = 4'hF; i_done = 0; i_data = 32'hA5A5A5A5; i_tx_cts = 1; i_tx_idle = 1;
        @(negedge clk); #1;
        vectors++;
        if ({o_idle, o_cts, o_tx_data, o_tx_req, o_grant_id, o_busy, o_pkt_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: idle=%b cts=%b data=%h req=%b id=%0d busy=%b pkt=%0d required all 0",
                     o_idle, o_cts, o_tx_data, o_tx_req, o_grant_id, o_busy, o_pkt_count);
        end
        i_want = 0; i_req = 0; i_tx_cts = 0; i_data = 0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 3;
        exp_pkt = 0;
    endtask

    task automatic test_first_grant();
        run_grant(4'b0001, 2);
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rr_pick(exp_last, 4'hF) !== order[i]) begin
                miscompares++;
                $display("FAIL rr_order: model picks %0d required %0d", rr_pick(exp_last, 4'hF), order[i]);
            end
            run_grant(4'hF, 3);
            if (i == 3) begin
                vectors++;
                if (o_pkt_count !== 16'd4) begin
                    miscompares++;
                    $display("FAIL pkt_after_4: got %0d required 4", o_pkt_count);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int c;
        i_want = 4'b0100; i_req = 0; i_done = 0; i_tx_idle = 1;
        @(negedge clk); #1;
        vectors++;
        if (o_idle !== 4'b0100 || o_grant_id !== 3'd2) begin
            miscompares++;
            $display("FAIL timeout_grant: idle=%b id=%0d required 0100 id=2", o_idle, o_grant_id);
        end
        i_want = 0;
        for (int b = 0; b < 3; b++) begin
            i_req = 4'b0100; i_data = $urandom; @(negedge clk);
        end
        i_req = 4'b1011;
        for (c = 0; c < 400; c++) begin
            #1;
            if (o_idle !== 4'b0100) break;
            @(negedge clk);
        end
        exp_pkt++;
        exp_last = 2;
        vectors++;
        if (c !== 255 || o_pkt_count !== 16'(exp_pkt) || o_idle !== 4'b0) begin
            miscompares++;
            $display("FAIL timeout: idle_cycles=%0d pkt=%0d idle=%b required 255 pkt=%0d idle=0000", c, o_pkt_count, o_idle, exp_pkt);
        end
        i_req = 0;
        wait_idle();
    endtask

    task automatic test_done_and_timeout();
        i_want = 4'b0001; i_req = 0; i_done = 0;
        @(negedge clk);
        for (int n = 0; n < 254; n++) @(negedge clk);
        i_done = 4'b0001;
        #1;
        vectors++;
        if (o_idle !== 4'b0001) begin
            miscompares++;
            $display("FAIL done_timeout_pre: idle=%b required 0001", o_idle);
        end
        @(negedge clk);
        i_done = 0; i_want = 0;
        exp_pkt++;
        exp_last = 0;
        #1;
        vectors++;
        if (o_pkt_count !== 16'(exp_pkt) || o_idle !== 4'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: pkt=%0d idle=%b busy=%b required pkt=%0d idle=0000 busy=1", o_pkt_count, o_idle, o_busy, exp_pkt);
        end
        wait_idle();
    endtask

    task automatic test_foreign_done();
        i_want = 4'b1000; i_tx_idle = 1;
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            i_done = 4'b0010;
            i_req = 4'b0010 | (4'($urandom) & 4'b1000);
            i_tx_cts = 1;
            i_data = $urandom;
            #1;
            vectors++;
            if (o_idle !== 4'b1000 || o_grant_id !== 3'd3 || o_cts[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL foreign_done: idle=%b id=%0d cts=%b required idle=1000 id=3 cts[1]=0", o_idle, o_grant_id, o_cts);
            end
            @(negedge clk);
        end
        i_done = 4'b1000; i_req = 0; i_want = 0;
        @(negedge clk);
        i_done = 0;
        exp_last = 3;
        exp_pkt++;
        wait_idle();
        vectors++;
        if (o_pkt_count !== 16'(exp_pkt)) begin
            miscompares++;
            $display("FAIL foreign_pkt: got %0d required %0d", o_pkt_count, exp_pkt);
        end
    endtask

    task automatic test_reset_mid_grant();
        int exp;
        exp = rr_pick(exp_last, 4'b0110);
        i_want = 4'b0110; i_tx_idle = 1;
        @(negedge clk);
        i_req = 4'hF; i_tx_cts = 1; i_data = $urandom;
        #1;
        vectors++;
        if (o_cts !== (4'b0001 << exp)) begin
            miscompares++;
            $display("FAIL pre_reset_cts: got %b required %b", o_cts, 4'b0001 << exp);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_idle, o_cts, o_tx_data, o_tx_req, o_grant_id, o_busy, o_pkt_count} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: idle=%b cts=%b data=%h req=%b id=%0d busy=%b pkt=%0d required all 0",
                     o_idle, o_cts, o_tx_data, o_tx_req, o_grant_id, o_busy, o_pkt_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 0; i_tx_cts = 0;
        exp_last = 3;
        exp_pkt = 0;
        run_grant(4'hF, 1);
    endtask

    task automatic test_tx_busy();
        int exp;
        i_tx_idle = 0; i_want = 4'b0110;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); #1;
            vectors++;
            if (o_busy !== 1'b0 || o_idle !== 4'b0) begin
                miscompares++;
                $display("FAIL tx_busy_hold: busy=%b idle=%b required 0 0000", o_busy, o_idle);
            end
        end
        exp = rr_pick(exp_last, 4'b0110);
        i_tx_idle = 1;
        @(negedge clk); #1;
        vectors++;
        if (o_idle !== (4'b0001 << exp) || o_grant_id !== 3'(exp)) begin
            miscompares++;
            $display("FAIL tx_idle_rise: idle=%b id=%0d required %b id=%0d", o_idle, o_grant_id, 4'b0001 << exp, exp);
        end
        i_done = 4'b0001 << exp; i_want = 0;
        @(negedge clk);
        i_done = 0;
        exp_last = exp;
        exp_pkt++;
        wait_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_grant(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)));
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_round_robin();
        test_timeout();
        test_done_and_timeout();
        test_foreign_done();
        test_reset_mid_grant();
        test_tx_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
